// File: rtl/dm_lsu_pkg.sv
// Shared constants and types for the data-memory load/store unit.
package dm_lsu_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [0:0] {INIT, RUN} state_e;

  // Stores accept B/H/W only; loads additionally accept BU/HU.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: request-side byte enables / store data replication and
// format checks, response-side sub-word selection with sign or zero extension.
import dm_lsu_pkg::*;

module lsu_align (
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_wdata,
  output logic        misalign,
  output logic        illegal,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] raw_word,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Request side: data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    byte_en    = 4'b0000;
    lane_wdata = req_wdata;
    misalign   = 1'b0;
    case (req_funct3[1:0])
      2'd0: begin
        byte_en    = 4'b0001 << req_off;
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        byte_en    = req_off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
        misalign   = req_off[0];
      end
      2'd2: begin
        byte_en  = 4'b1111;
        misalign = |req_off;
      end
      default: byte_en = 4'b0000;
    endcase
    illegal = !funct3_legal(req_we, req_funct3);
  end

  // Response side: select the addressed lane from the registered word and extend it.
  always_comb begin
    sel_byte  = raw_word[{rsp_off, 3'b000} +: 8];
    sel_half  = raw_word[{rsp_off[1], 4'b0000} +: 16];
    load_data = raw_word;
    case (rsp_funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_BU:   load_data = {24'd0, sel_byte};
      F3_HU:   load_data = {16'd0, sel_half};
      default: load_data = raw_word;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Word-organised data memory with RISC-V sub-word loads/stores, a valid/ready request
// channel and a one-cycle registered response. Array is cleared by a sweep after reset.
import dm_lsu_pkg::*;

module data_memory_lsu #(
  parameter int unsigned DEPTH          = 32,
  parameter int unsigned IDX_W          = $clog2(DEPTH),
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  logic [31:0]      mem [DEPTH];

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [31:0]      raw_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             load_ok_q;

  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             range_err;
  logic             req_err;
  logic             wr_en;
  logic             sweep_wr;
  logic [3:0]       byte_en;
  logic [31:0]      lane_wdata;
  logic             misalign;
  logic             illegal;
  logic [31:0]      load_data;

  lsu_align u_align (
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_off    (req_addr[1:0]),
    .req_wdata  (req_wdata),
    .byte_en    (byte_en),
    .lane_wdata (lane_wdata),
    .misalign   (misalign),
    .illegal    (illegal),
    .rsp_funct3 (f3_q),
    .rsp_off    (off_q),
    .raw_word   (raw_q),
    .load_data  (load_data)
  );

  // Request decode: handshake, word index and error classification.
  always_comb begin
    req_ready = (state_q == RUN);
    accept    = req_valid & req_ready;
    idx       = req_addr[IDX_W+1:2];
    range_err = {2'b00, req_addr[31:2]} >= DEPTH;
    req_err   = misalign | illegal | range_err;
    wr_en     = accept & req_we & ~req_err;
    sweep_wr  = (state_q == INIT) && CLEAR_ON_RESET;
    rsp_rdata = load_ok_q ? load_data : 32'd0;
  end

  // Array: sweep clear during INIT, otherwise per-byte-enable stores (no reset on contents).
  always_ff @(posedge clk) begin
    if (sweep_wr) begin
      mem[cnt_q] <= 32'd0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
      end
    end
  end

  // Control FSM, sweep counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      raw_q     <= 32'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      load_ok_q <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept & req_err;
      load_ok_q <= accept & ~req_we & ~req_err;
      // Only legal loads touch the array, so an out-of-range index is never read.
      if (accept & ~req_we & ~req_err) begin
        raw_q <= mem[idx];
      end
      if (accept) begin
        f3_q  <= req_funct3;
        off_q <= req_addr[1:0];
      end
      case (state_q)
        INIT: begin
          if (!CLEAR_ON_RESET || cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q   <= RUN;
            init_done <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN:     state_q <= RUN;
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu against a byte-array reference model.
module tb_data_memory_lsu;

  localparam int unsigned DEPTH = 32;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] exp;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] mb [DEPTH*4];

  data_memory_lsu #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH*4); i++) mb[i] = 8'h00;
  endtask

  // Reference: memory as bytes, access size 1<<funct3[1:0], natural alignment required.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int unsigned size;
    logic        legal;
    logic [31:0] v;
    size  = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || (a % size != 0) || (a >= DEPTH*4);
    rd    = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < int'(size); i++) mb[a+i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < int'(size); i++) v = v | (32'(mb[a+i]) << (8*i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        rd = v;
      end
    end
  endfunction

  // Present one request for one clock; returns #1 after the edge. Valid stays as given.
  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int   n;
    logic saw;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_rdata !== 32'd0 || init_done !== 1'b0) begin
      $display("FAIL reset_state: ready=%b valid=%b err=%b rdata=%h done=%b, want all 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata, init_done);
      nerr++;
    end
    rst = 1'b0;
    // A store offered during the sweep must be ignored.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0; req_wdata = 32'hFFFFFFFF;
    n = 0; saw = 1'b0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (rsp_valid === 1'b1) saw = 1'b1;
    end
    req_valid = 1'b0;
    nvec++;
    if (n != 32 || init_done !== 1'b1) begin
      $display("FAIL sweep_len: cycles=%0d done=%b, want 32 done=1", n, init_done);
      nerr++;
    end
    nvec++;
    if (saw !== 1'b0) begin
      $display("FAIL init_ignore: rsp_valid seen=%b, want 0", saw);
      nerr++;
    end
    clear_model();
    for (int w = 0; w < 4; w++) begin
      drive(1'b1, 1'b0, 3'd2, 32'(w * 36), 32'd0);
      nvec++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
        $display("FAIL reset_clear: word %0d valid=%b err=%b rdata=%h, want 1 0 00000000",
                 w * 9, rsp_valid, rsp_err, rsp_rdata);
        nerr++;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_subword();
    op_t         t[8];
    logic        e;
    logic [31:0] r;
    t = '{
      '{1'b1, 3'd2, 32'h10, 32'h8000_00FF, 1'b0, 32'h0000_0000},
      '{1'b0, 3'd0, 32'h10, 32'h0,         1'b0, 32'hFFFF_FFFF},
      '{1'b0, 3'd4, 32'h10, 32'h0,         1'b0, 32'h0000_00FF},
      '{1'b0, 3'd1, 32'h12, 32'h0,         1'b0, 32'hFFFF_8000},
      '{1'b1, 3'd2, 32'h04, 32'h1122_3344, 1'b0, 32'h0000_0000},
      '{1'b1, 3'd0, 32'h05, 32'h0000_00AB, 1'b0, 32'h0000_0000},
      '{1'b0, 3'd2, 32'h04, 32'h0,         1'b0, 32'h1122_AB44},
      '{1'b0, 3'd5, 32'h06, 32'h0,         1'b0, 32'h0000_1122}
    };
    for (int i = 0; i < 8; i++) begin
      model(t[i].we, t[i].f3, t[i].a, t[i].wd, e, r);
      drive(1'b1, t[i].we, t[i].f3, t[i].a, t[i].wd);
      req_valid = 1'b0;
      nvec++;
      if (rsp_valid !== 1'b1 || rsp_err !== t[i].err || rsp_rdata !== t[i].exp) begin
        $display("FAIL subword[%0d]: valid=%b err=%b rdata=%h, want 1 %b %h",
                 i, rsp_valid, rsp_err, rsp_rdata, t[i].err, t[i].exp);
        nerr++;
      end
    end
  endtask

  task automatic test_errors();
    op_t         t[8];
    logic        e;
    logic [31:0] r;
    t = '{
      '{1'b0, 3'd2, 32'h02,      32'h0,         1'b1, 32'h0},
      '{1'b1, 3'd1, 32'h03,      32'h0000_FFFF, 1'b1, 32'h0},
      '{1'b0, 3'd3, 32'h10,      32'h0,         1'b1, 32'h0},
      '{1'b0, 3'd2, DEPTH*4,     32'h0,         1'b1, 32'h0},
      '{1'b1, 3'd4, 32'h04,      32'hFFFF_FFFF, 1'b1, 32'h0},
      '{1'b0, 3'd2, 32'h00,      32'h0,         1'b0, 32'h0000_0000},
      '{1'b0, 3'd2, 32'h10,      32'h0,         1'b0, 32'h8000_00FF},
      '{1'b0, 3'd2, 32'h04,      32'h0,         1'b0, 32'h1122_AB44}
    };
    for (int i = 0; i < 8; i++) begin
      model(t[i].we, t[i].f3, t[i].a, t[i].wd, e, r);
      drive(1'b1, t[i].we, t[i].f3, t[i].a, t[i].wd);
      req_valid = 1'b0;
      nvec++;
      if (rsp_valid !== 1'b1 || rsp_err !== t[i].err || rsp_rdata !== t[i].exp) begin
        $display("FAIL errors[%0d]: valid=%b err=%b rdata=%h, want 1 %b %h",
                 i, rsp_valid, rsp_err, rsp_rdata, t[i].err, t[i].exp);
        nerr++;
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t         t[4];
    logic        e;
    logic [31:0] r;
    t = '{
      '{1'b1, 3'd2, 32'h20, 32'hDEAD_BEEF, 1'b0, 32'h0},
      '{1'b0, 3'd2, 32'h20, 32'h0,         1'b0, 32'hDEAD_BEEF},
      '{1'b1, 3'd0, 32'h21, 32'h0000_0011, 1'b0, 32'h0},
      '{1'b0, 3'd2, 32'h20, 32'h0,         1'b0, 32'hDEAD_11EF}
    };
    for (int i = 0; i < 4; i++) begin
      model(t[i].we, t[i].f3, t[i].a, t[i].wd, e, r);
      drive(1'b1, t[i].we, t[i].f3, t[i].a, t[i].wd);
      nvec++;
      if (rsp_valid !== 1'b1 || rsp_err !== t[i].err || rsp_rdata !== t[i].exp) begin
        $display("FAIL b2b[%0d]: valid=%b err=%b rdata=%h, want 1 %b %h",
                 i, rsp_valid, rsp_err, rsp_rdata, t[i].err, t[i].exp);
        nerr++;
      end
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    nvec++;
    if (rsp_valid !== 1'b0) begin
      $display("FAIL b2b_idle: valid=%b, want 0", rsp_valid);
      nerr++;
    end
  endtask

  task automatic test_random();
    logic        v;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        e;
    logic [31:0] r;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, DEPTH*4 + 7));
      wd = $urandom;
      e  = 1'b0;
      r  = 32'd0;
      if (v) model(we, f3, a, wd, e, r);
      drive(v, we, f3, a, wd);
      nvec++;
      if (rsp_valid !== v || (v && (rsp_err !== e || rsp_rdata !== r))) begin
        $display("FAIL random[%0d]: we=%b f3=%0d a=%h valid=%b err=%b rdata=%h, want %b %b %h",
                 i, we, f3, a, rsp_valid, rsp_err, rsp_rdata, v, e, r);
        nerr++;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int          n;
    logic        e;
    logic [31:0] r;
    model(1'b1, 3'd2, 32'h40, 32'hCAFE_F00D, e, r);
    drive(1'b1, 1'b1, 3'd2, 32'h40, 32'hCAFE_F00D);
    nvec++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      $display("FAIL rstmid_pre: valid=%b err=%b, want 1 0", rsp_valid, rsp_err);
      nerr++;
    end
    req_addr  = 32'h44;
    req_wdata = 32'h1234_5678;
    #1 rst = 1'b1;
    #1;
    nvec++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0) begin
      $display("FAIL rstmid_drop: valid=%b ready=%b done=%b, want 0 0 0",
               rsp_valid, req_ready, init_done);
      nerr++;
    end
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    nvec++;
    if (n != 32) begin
      $display("FAIL rstmid_sweep: cycles=%0d, want 32", n);
      nerr++;
    end
    clear_model();
    for (int i = 0; i < 3; i++) begin
      model(1'b0, 3'd2, 32'h40 + 32'(4*i), 32'd0, e, r);
      drive(1'b1, 1'b0, 3'd2, 32'h40 + 32'(4*i), 32'd0);
      nvec++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
        $display("FAIL rstmid_clear[%0d]: valid=%b err=%b rdata=%h, want 1 0 00000000",
                 i, rsp_valid, rsp_err, rsp_rdata);
        nerr++;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_subword();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
